// File: rtl/sim_run_ctrl.sv
// Run controller: cycle counter, prioritised fail/finish/timeout verdict, dump window, verdict report port.
// Latency: verdict latched at the edge ending the deciding RUN cycle; status_valid rises DRAIN_CYC+1 cycles later.
// Backpressure: status_* held in REPORT until status_ready; optional watchdog built only with SIM_RUN_CTRL_WDOG_EN.
module sim_run_ctrl #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 64,
  parameter int DRAIN_CYC = 16,
  parameter int WDOG_CYC  = 4096,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [CNT_W-1:0] dump_start,
  input  logic [CNT_W-1:0] dump_stop,
  input  logic [N_CH-1:0]  finish,
  input  logic [N_CH-1:0]  fail,
  input  logic             progress,
  output logic             running,
  output logic             dump_en,
  output logic             status_valid,
  input  logic             status_ready,
  output logic [2:0]       status_reason,
  output logic [CH_W-1:0]  status_chan,
  output logic [CNT_W-1:0] status_cycles,
  output logic             done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_REPORT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [2:0] R_PASS    = 3'd1;
  localparam logic [2:0] R_FAIL    = 3'd2;
  localparam logic [2:0] R_TIMEOUT = 3'd3;
  localparam logic [2:0] R_WDOG    = 3'd4;

  // Drain counter runs 0..DRAIN_CYC-1; with DRAIN_CYC=0 the DRAIN state is never entered.
  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0]   max_q, dstart_q, dstop_q;
  logic [2:0]         reason_q;
  logic [CH_W-1:0]    chan_q;
  logic [CNT_W-1:0]   cycles_q;

  logic [CH_W-1:0]    fail_idx, fin_idx;
  logic               timeout_hit, wdog_hit;
  logic               verdict;
  logic [2:0]         v_reason;
  logic [CH_W-1:0]    v_chan;

`ifdef SIM_RUN_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_CYC);
  logic [WDOG_W-1:0] wdog_q;

  assign wdog_hit = (wdog_q >= WDOG_LIM);

  // Watchdog: cleared on RUN entry and on each progress pulse, otherwise counts up to the limit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wdog_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      wdog_q <= '0;
    end else if (state_q == S_RUN) begin
      if (progress)      wdog_q <= '0;
      else if (!wdog_hit) wdog_q <= wdog_q + 1'b1;
    end
  end
`else
  // Without the watchdog, progress and WDOG_CYC have no function.
  logic unused_wdog;
  assign unused_wdog = progress | (WDOG_CYC == 0);
  assign wdog_hit    = 1'b0;
`endif

  assign timeout_hit = (max_q != '0) && (count_q >= max_q);

  // Lowest-index requester per source type: scan downward so the lowest set bit is written last.
  always_comb begin
    fail_idx = '0;
    fin_idx  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (fail[i])   fail_idx = CH_W'(i);
      if (finish[i]) fin_idx  = CH_W'(i);
    end
  end

  // Verdict priority: fail > finish > timeout > watchdog.
  always_comb begin
    verdict  = 1'b0;
    v_reason = 3'd0;
    v_chan   = '0;
    if (|fail) begin
      verdict  = 1'b1;
      v_reason = R_FAIL;
      v_chan   = fail_idx;
    end else if (|finish) begin
      verdict  = 1'b1;
      v_reason = R_PASS;
      v_chan   = fin_idx;
    end else if (timeout_hit) begin
      verdict  = 1'b1;
      v_reason = R_TIMEOUT;
    end else if (wdog_hit) begin
      verdict  = 1'b1;
      v_reason = R_WDOG;
    end
  end

  // Next-state logic for the run FSM, cycle counter and drain counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          count_d = '0;
        end
      end
      S_RUN: begin
        if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
        if (verdict) begin
          state_d = (DRAIN_CYC > 0) ? S_DRAIN : S_REPORT;
          drain_d = '0;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_REPORT;
        else                       drain_d = drain_q + 1'b1;
      end
      S_REPORT: begin
        if (status_ready) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; limits captured on start, verdict fields captured on the deciding RUN cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      drain_q  <= '0;
      max_q    <= '0;
      dstart_q <= '0;
      dstop_q  <= '0;
      reason_q <= '0;
      chan_q   <= '0;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      drain_q <= drain_d;
      if (state_q == S_IDLE && start) begin
        max_q    <= max_cycles;
        dstart_q <= dump_start;
        dstop_q  <= dump_stop;
      end
      if (state_q == S_RUN && verdict) begin
        reason_q <= v_reason;
        chan_q   <= v_chan;
        cycles_q <= count_q;
      end
    end
  end

  logic show_status;
  assign show_status = (state_q == S_REPORT) || (state_q == S_DONE);

  assign running       = (state_q == S_RUN);
  assign status_valid  = (state_q == S_REPORT);
  assign done          = (state_q == S_DONE);
  assign status_reason = show_status ? reason_q : '0;
  assign status_chan   = show_status ? chan_q   : '0;
  assign status_cycles = show_status ? cycles_q : '0;

  // Count is frozen during DRAIN, so the window state there follows the count one past the verdict.
  assign dump_en = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                   (count_q >= dstart_q) &&
                   ((dstop_q == '0) || (count_q < dstop_q));

endmodule

// File: tb/tb_sim_run_ctrl.sv
module tb_sim_run_ctrl;
  localparam int N_CH      = 4;
  localparam int CNT_W     = 64;
  localparam int DRAIN_CYC = 16;
  localparam int WDOG_CYC  = 64;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] max_cycles = '0;
  logic [CNT_W-1:0] dump_start = '0;
  logic [CNT_W-1:0] dump_stop  = '0;
  logic [N_CH-1:0]  finish = '0;
  logic [N_CH-1:0]  fail   = '0;
  logic             progress = 1'b0;
  logic             status_ready = 1'b0;
  logic             running, dump_en, status_valid, done;
  logic [2:0]       status_reason;
  logic [1:0]       status_chan;
  logic [CNT_W-1:0] status_cycles;

  sim_run_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC), .WDOG_CYC(WDOG_CYC)) dut (
    .clock(clock), .reset(reset), .start(start), .max_cycles(max_cycles),
    .dump_start(dump_start), .dump_stop(dump_stop), .finish(finish), .fail(fail),
    .progress(progress), .running(running), .dump_en(dump_en),
    .status_valid(status_valid), .status_ready(status_ready),
    .status_reason(status_reason), .status_chan(status_chan),
    .status_cycles(status_cycles), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  reason;
    logic [1:0]  chan;
    logic [63:0] cycles;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  longint unsigned cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic step_run();
    step();
    cnt++;
  endtask

  task automatic push_exp(input logic [2:0] r, input logic [1:0] c, input logic [63:0] cy);
    exp_t e;
    e.reason = r;
    e.chan   = c;
    e.cycles = cy;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; finish = '0; fail = '0; status_ready = 1'b0;
    progress = 1'b1;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic begin_run(input logic [63:0] mx, input logic [63:0] ds, input logic [63:0] dp);
    max_cycles = mx; dump_start = ds; dump_stop = dp;
    start = 1'b1;
    step();
    start = 1'b0;
    cnt = 0;
    check("running_after_start", running, 1);
  endtask

  task automatic run_to(input longint unsigned k);
    while (cnt < k) step_run();
  endtask

  // Called in the verdict cycle with sources already driven; dd = expected dump_en during DRAIN (-1 = skip).
  task automatic wait_report(input int lat, input int dd, input int hold);
    exp_t e;
    int n;
    step();
    finish = '0; fail = '0;
    n = 1;
    if (!status_valid) check("drain_not_running", running, 0);
    while (!status_valid && n < 60) begin
      if (dd >= 0) check("drain_dump", dump_en, dd[0]);
      step();
      n++;
    end
    check("report_seen", status_valid, 1);
    check("report_latency", n, lat);
    check("report_dump_off", dump_en, 0);
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("reason", status_reason, e.reason);
      check("chan", status_chan, e.chan);
      check("cycles", status_cycles, e.cycles);
      for (int i = 0; i < hold; i++) begin
        step();
        check("hold_valid", status_valid, 1);
        check("hold_reason", status_reason, e.reason);
        check("hold_chan", status_chan, e.chan);
        check("hold_cycles", status_cycles, e.cycles);
      end
      status_ready = 1'b1;
      step();
      status_ready = 1'b0;
      check("done_set", done, 1);
      check("valid_clear", status_valid, 0);
      check("retained_reason", status_reason, e.reason);
      check("retained_cycles", status_cycles, e.cycles);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic ok;
    // Reset state.
    reset = 1'b0;
    step();
    check("rst_running", running, 0);
    check("rst_dump", dump_en, 0);
    check("rst_valid", status_valid, 0);
    check("rst_done", done, 0);
    check("rst_reason", status_reason, 0);
    check("rst_cycles", status_cycles, 0);

    // finish[2] at count 100 with dump window 10..19, ready held low for 30 cycles.
    do_reset();
    begin_run(0, 10, 20);
    while (cnt < 100) begin
      check("dump_window", dump_en, (cnt >= 10 && cnt < 20));
      step_run();
    end
    finish = 4'b0100;
    push_exp(3'd1, 2'd2, 64'd100);
    wait_report(DRAIN_CYC + 1, 0, 30);

    // fail[3] beats finish[0]; open-ended dump window from count 0 through DRAIN.
    do_reset();
    begin_run(0, 0, 0);
    check("dump_from_zero", dump_en, 1);
    run_to(50);
    check("dump_open", dump_en, 1);
    fail = 4'b1000; finish = 4'b0001;
    push_exp(3'd2, 2'd3, 64'd50);
    wait_report(DRAIN_CYC + 1, 1, 0);

    // fail[1] and fail[3] with finish[0]: lowest fail index wins.
    do_reset();
    begin_run(0, 0, 0);
    run_to(50);
    fail = 4'b1010; finish = 4'b0001;
    push_exp(3'd2, 2'd1, 64'd50);
    wait_report(DRAIN_CYC + 1, -1, 0);

    // fail and finish on the same channel resolve to fail.
    do_reset();
    begin_run(0, 0, 0);
    run_to(7);
    fail = 4'b0100; finish = 4'b0100;
    push_exp(3'd2, 2'd2, 64'd7);
    wait_report(DRAIN_CYC + 1, -1, 0);

    // Lowest finish index wins.
    do_reset();
    begin_run(0, 0, 0);
    run_to(3);
    finish = 4'b1010;
    push_exp(3'd1, 2'd1, 64'd3);
    wait_report(DRAIN_CYC + 1, -1, 0);

    // Timeout at max_cycles=200.
    do_reset();
    begin_run(200, 0, 0);
    run_to(200);
    check("no_early_timeout", running, 1);
    push_exp(3'd3, 2'd0, 64'd200);
    wait_report(DRAIN_CYC + 1, -1, 0);

    // max_cycles=0: no timeout over 10000 cycles; start held high must not restart the run.
    do_reset();
`ifndef SIM_RUN_CTRL_WDOG_EN
    progress = 1'b0;
`endif
    begin_run(0, 0, 0);
    start = 1'b1;
    ok = 1'b1;
    while (cnt < 10000) begin
      step_run();
      if (!running || status_valid) ok = 1'b0;
    end
    check("no_timeout_10000", ok, 1);
    finish = 4'b0001;
    push_exp(3'd1, 2'd0, 64'd10000);
    wait_report(DRAIN_CYC + 1, -1, 0);
    step();
    step();
    check("done_sticky", done, 1);
    check("done_no_restart", running, 0);
    start = 1'b0;

    // Reset in DRAIN aborts with no report.
    do_reset();
    begin_run(0, 0, 0);
    run_to(5);
    finish = 4'b0010;
    step();
    finish = '0;
    step();
    step();
    check("in_drain_no_valid", status_valid, 0);
    reset = 1'b0;
    step();
    check("abort_running", running, 0);
    check("abort_dump", dump_en, 0);
    check("abort_valid", status_valid, 0);
    check("abort_reason", status_reason, 0);
    check("abort_chan", status_chan, 0);
    check("abort_cycles", status_cycles, 0);
    reset = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (status_valid || done || running) ok = 1'b0;
    end
    check("abort_no_report", ok, 1);

`ifdef SIM_RUN_CTRL_WDOG_EN
    // Progress every 32 cycles keeps the watchdog quiet; after the last pulse it fires 65 counts later.
    do_reset();
    progress = 1'b0;
    begin_run(0, 0, 0);
    while (cnt < 320) begin
      progress = ((cnt % 32) == 31);
      step_run();
    end
    progress = 1'b0;
    check("wdog_kept_alive", running, 1);
    run_to(384);
    check("wdog_not_early", running, 1);
    push_exp(3'd4, 2'd0, 64'd384);
    wait_report(DRAIN_CYC + 1, -1, 0);
`endif

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
